// File: rtl/q2_io_pkg.sv
// q2 console shared types: transmit FSM states, HD44780 command bytes, init sequence.
// No logic; imported by q2_io_fifo and q2_lcd_io.
package q2_io_pkg;

  localparam logic [11:0] IO_ADDR_DEF  = 12'hFFF;
  localparam logic [7:0]  CMD_CLEAR    = 8'h01;
  localparam logic [7:0]  CMD_SET_ADDR = 8'h80;
  localparam logic [7:0]  REPLACE_CHAR = 8'h3F;

  localparam logic [7:0]  INIT_WAKE    = 8'h30;  // sent as high nibble only
  localparam logic [7:0]  INIT_4BIT    = 8'h20;  // sent as high nibble only
  localparam logic [7:0]  INIT_FUNCSET = 8'h28;
  localparam logic [7:0]  INIT_DISP_ON = 8'h0C;
  localparam logic [7:0]  INIT_ENTRY   = 8'h06;
  localparam int          INIT_STEPS   = 8;

  typedef enum logic [3:0] {
    IDLE, INIT_WAIT, HI_SETUP, HI_EN, HI_HOLD, LO_SETUP, LO_EN, LO_HOLD, WAIT
  } lcd_state_e;

  // Returns {nibble_only, byte} for one power-on init step.
  function automatic logic [8:0] init_step(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1, 3'd2: init_step = {1'b1, INIT_WAKE};
      3'd3:             init_step = {1'b1, INIT_4BIT};
      3'd4:             init_step = {1'b0, INIT_FUNCSET};
      3'd5:             init_step = {1'b0, INIT_DISP_ON};
      3'd6:             init_step = {1'b0, INIT_ENTRY};
      default:          init_step = {1'b0, CMD_CLEAR};
    endcase
  endfunction

endpackage

// File: rtl/q2_io_fifo.sv
// Generic synchronous FIFO, combinational read of the head entry.
// Latency: pushed entry visible at dout the cycle after the push.
// Backpressure: push while full is dropped unless a pop happens in the same cycle.
module q2_io_fifo
  import q2_io_pkg::*;
#(
  parameter int W     = 9,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
  logic         do_push, do_pop;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q + {{AW{1'b0}}, do_push};
    rd_d = rd_q + {{AW{1'b0}}, do_pop};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/q2_lcd_io.sv
// q2 console: bus writes queued and sent to a 4-bit HD44780 LCD, bus reads return synced keys.
// Latency: push 2 clk after wrm rises, keys 2 clk; Q2_LCD_INIT_EN adds a power-on init sequence.
// Backpressure: none on the bus; pushes into a full FIFO are dropped and set sticky ovf.
module q2_lcd_io
  import q2_io_pkg::*;
#(
  parameter logic [11:0] IO_ADDR    = IO_ADDR_DEF,
  parameter int          FIFO_DEPTH = 4,
  parameter int          EN_CYCLES  = 1,
  parameter int          CMD_WAIT   = 5,
  parameter int          CLR_WAIT   = 160,
  parameter int          POR_WAIT   = 1500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] abus,
  input  logic [11:0] dbus_in,
  output logic [11:0] dbus_out,
  output logic        dbus_oe,
  input  logic        rdm,
  input  logic        wrm,
  input  logic [11:0] keys_n,
  output logic        lcd_rs,
  output logic        lcd_e,
  output logic [3:0]  lcd_d,
  output logic        full,
  output logic        ovf
);

  localparam int MAX_WAIT = (CLR_WAIT > POR_WAIT) ? CLR_WAIT : POR_WAIT;
  localparam int WAIT_W   = $clog2(MAX_WAIT) + 1;
  localparam logic [WAIT_W-1:0] EN_LD  = WAIT_W'(EN_CYCLES - 1);
  localparam logic [WAIT_W-1:0] CMD_LD = WAIT_W'(CMD_WAIT - 1);
  localparam logic [WAIT_W-1:0] CLR_LD = WAIT_W'(CLR_WAIT - 1);
  localparam logic [WAIT_W-1:0] POR_LD = WAIT_W'(POR_WAIT - 1);
`ifdef Q2_LCD_INIT_EN
  localparam logic INIT_ON = 1'b1;
`else
  localparam logic INIT_ON = 1'b0;
`endif
  localparam lcd_state_e RST_STATE = INIT_ON ? INIT_WAIT : IDLE;

  logic              wrm_q, wr_pulse_q, wr_pulse_d;
  logic [11:0]       addr_q, key_meta_q, key_q;
  logic [8:0]        dat_q, cur_q, cur_d, push_dat, fifo_dout;
  logic              ovf_q, ovf_d, push_vld, pop, fifo_empty;
  lcd_state_e        state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic              nib_q, nib_d, init_act_q, init_act_d;
  logic [2:0]        init_idx_q, init_idx_d;
  logic [8:0]        step;
  logic              unused_hi;

  assign unused_hi  = ^dbus_in[11:9];
  assign wr_pulse_d = wrm && !wrm_q;
  assign dbus_oe    = rdm && (abus == IO_ADDR);
  assign dbus_out   = dbus_oe ? key_q : 12'h000;
  assign ovf        = ovf_q;

  always_comb begin
    push_vld = 1'b0;
    push_dat = '0;
    if (wr_pulse_q && addr_q == IO_ADDR) begin
      if (!dat_q[8]) begin
        push_vld = 1'b1;
        push_dat = {1'b1, (dat_q[7:0] >= 8'h20 && dat_q[7:0] <= 8'h7E) ? dat_q[7:0] : REPLACE_CHAR};
      end else if (dat_q[7]) begin
        push_vld = 1'b1;
        push_dat = {1'b0, CMD_SET_ADDR | {1'b0, dat_q[6:0]}};
      end else if (dat_q[0]) begin
        push_vld = 1'b1;
        push_dat = {1'b0, CMD_CLEAR};
      end
    end
  end

  q2_io_fifo #(.W(9), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push_vld),
    .pop  (pop),
    .din  (push_dat),
    .dout (fifo_dout),
    .full (full),
    .empty(fifo_empty)
  );

  assign ovf_d = ovf_q || (push_vld && full && !pop);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cur_d      = cur_q;
    nib_d      = nib_q;
    init_act_d = init_act_q;
    init_idx_d = init_idx_q;
    pop        = 1'b0;
    step       = init_step(init_idx_q + 3'd1);
    case (state_q)
      IDLE: if (!fifo_empty) begin
        pop     = 1'b1;
        cur_d   = fifo_dout;
        nib_d   = 1'b0;
        state_d = HI_SETUP;
      end
      INIT_WAIT: if (cnt_q == '0) begin
        step       = init_step(3'd0);
        cur_d      = {1'b0, step[7:0]};
        nib_d      = step[8];
        init_idx_d = 3'd0;
        state_d    = HI_SETUP;
      end else cnt_d = cnt_q - 1'b1;
      HI_SETUP: begin state_d = HI_EN; cnt_d = EN_LD; end
      HI_EN: if (cnt_q == '0) state_d = HI_HOLD; else cnt_d = cnt_q - 1'b1;
      HI_HOLD: if (nib_q) begin state_d = WAIT; cnt_d = CMD_LD; end else state_d = LO_SETUP;
      LO_SETUP: begin state_d = LO_EN; cnt_d = EN_LD; end
      LO_EN: if (cnt_q == '0) state_d = LO_HOLD; else cnt_d = cnt_q - 1'b1;
      LO_HOLD: begin
        state_d = WAIT;
        cnt_d   = (cur_q == {1'b0, CMD_CLEAR}) ? CLR_LD : CMD_LD;
      end
      WAIT: if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      else if (init_act_q && init_idx_q != 3'(INIT_STEPS - 1)) begin
        cur_d      = {1'b0, step[7:0]};
        nib_d      = step[8];
        init_idx_d = init_idx_q + 3'd1;
        state_d    = HI_SETUP;
      end else begin
        init_act_d = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode straight from state so an async reset drops lcd_e at once.
  always_comb begin
    lcd_e  = (state_q == HI_EN) || (state_q == LO_EN);
    lcd_rs = 1'b0;
    lcd_d  = 4'h0;
    case (state_q)
      HI_SETUP, HI_EN, HI_HOLD: begin lcd_rs = cur_q[8]; lcd_d = cur_q[7:4]; end
      LO_SETUP, LO_EN, LO_HOLD: begin lcd_rs = cur_q[8]; lcd_d = cur_q[3:0]; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrm_q      <= 1'b0;
      wr_pulse_q <= 1'b0;
      addr_q     <= '0;
      dat_q      <= '0;
      key_meta_q <= 12'hFFF;
      key_q      <= 12'hFFF;
      ovf_q      <= 1'b0;
      state_q    <= RST_STATE;
      cnt_q      <= INIT_ON ? POR_LD : '0;
      cur_q      <= '0;
      nib_q      <= 1'b0;
      init_act_q <= INIT_ON;
      init_idx_q <= 3'd0;
    end else begin
      wrm_q      <= wrm;
      wr_pulse_q <= wr_pulse_d;
      addr_q     <= abus;
      dat_q      <= dbus_in[8:0];
      key_meta_q <= keys_n;
      key_q      <= key_meta_q;
      ovf_q      <= ovf_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cur_q      <= cur_d;
      nib_q      <= nib_d;
      init_act_q <= init_act_d;
      init_idx_q <= init_idx_d;
    end
  end

endmodule

// File: tb/tb_q2_lcd_io.sv
// Directed bench for q2_lcd_io: captures {rs,d} at each lcd_e falling edge and checks order and timing.
module tb_q2_lcd_io;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] abus = 12'h000, dbus_in = 12'h000, keys_n = 12'h000;
  logic        rdm = 1'b0, wrm = 1'b0;
  logic [11:0] dbus_out;
  logic        dbus_oe, lcd_rs, lcd_e, full, ovf;
  logic [3:0]  lcd_d;

  int n_chk = 0, n_fail = 0, cyc = 0;
  logic [4:0] nq[$];
  int         tq[$];
  logic       e_prev = 1'b0;
  logic [4:0] init_exp [12] = '{5'h03, 5'h03, 5'h03, 5'h02, 5'h02, 5'h08,
                                5'h00, 5'h0C, 5'h00, 5'h06, 5'h00, 5'h01};

  q2_lcd_io dut (
    .clk(clk), .rst(rst), .abus(abus), .dbus_in(dbus_in), .dbus_out(dbus_out),
    .dbus_oe(dbus_oe), .rdm(rdm), .wrm(wrm), .keys_n(keys_n), .lcd_rs(lcd_rs),
    .lcd_e(lcd_e), .lcd_d(lcd_d), .full(full), .ovf(ovf)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    if (!rst) e_prev = 1'b0;
    else begin
      if (e_prev && !lcd_e) begin
        nq.push_back({lcd_rs, lcd_d});
        tq.push_back(cyc);
      end
      e_prev = lcd_e;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [11:0] a, input logic [11:0] d);
    @(negedge clk);
    abus = a; dbus_in = d; wrm = 1'b1;
    @(negedge clk);
    wrm = 1'b0;
  endtask

  task automatic wait_nib(input int n, input int budget);
    int c = 0;
    while (nq.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk("nibble_timeout", 32'(nq.size() >= n), 32'd1);
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clr_q();
    nq.delete();
    tq.delete();
  endtask

  initial begin
    rdm = 1'b1; abus = 12'hFFF;
    settle(3);
    chk("rst_lcd_e", 32'(lcd_e), 32'd0);
    chk("rst_lcd_rs", 32'(lcd_rs), 32'd0);
    chk("rst_lcd_d", 32'(lcd_d), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_key", 32'(dbus_out), 32'hFFF);
    rdm = 1'b0;
    #1 chk("rst_oe", 32'(dbus_oe), 32'd0);
    keys_n = 12'hFFF;
    @(negedge clk) rst = 1'b1;

`ifdef Q2_LCD_INIT_EN
    wait_nib(12, 3000);
    for (int i = 0; i < 12; i++) chk("init_seq", 32'(nq[i]), 32'(init_exp[i]));
    settle(200);
`endif

    // Two chars back to back: intra-byte and inter-byte spacing.
    clr_q();
    bus_write(12'hFFF, 12'h041);
    bus_write(12'hFFF, 12'h042);
    wait_nib(4, 100);
    chk("t1_hi_a", 32'(nq[0]), 32'h14);
    chk("t1_lo_a", 32'(nq[1]), 32'h11);
    chk("t1_hi_b", 32'(nq[2]), 32'h14);
    chk("t1_lo_b", 32'(nq[3]), 32'h12);
    chk("t1_gap_hilo", 32'(tq[1] - tq[0]), 32'd3);
    chk("t1_gap_cmd", 32'(tq[2] - tq[1]), 32'd9);
    settle(20);

    // Clear, ignored command, set address.
    clr_q();
    bus_write(12'hFFF, 12'h101);
    bus_write(12'hFFF, 12'h102);
    bus_write(12'hFFF, 12'h1C0);
    wait_nib(4, 400);
    chk("t2_clr_hi", 32'(nq[0]), 32'h00);
    chk("t2_clr_lo", 32'(nq[1]), 32'h01);
    chk("t2_addr_hi", 32'(nq[2]), 32'h0C);
    chk("t2_addr_lo", 32'(nq[3]), 32'h00);
    chk("t2_gap_clr", 32'(tq[2] - tq[1]), 32'd164);
    settle(30);
    chk("t2_count", 32'(nq.size()), 32'd4);

    // Non-printables replaced; other address ignored.
    clr_q();
    bus_write(12'hFFF, 12'h01F);
    bus_write(12'hFFF, 12'h07F);
    bus_write(12'hFFE, 12'h041);
    wait_nib(4, 100);
    chk("t3_lo_hi", 32'(nq[0]), 32'h13);
    chk("t3_lo_lo", 32'(nq[1]), 32'h1F);
    chk("t3_hi_hi", 32'(nq[2]), 32'h13);
    chk("t3_hi_lo", 32'(nq[3]), 32'h1F);
    settle(40);
    chk("t3_count", 32'(nq.size()), 32'd4);

    // Overflow: six writes, one in flight + four queued, sixth dropped.
    clr_q();
    for (int k = 0; k < 6; k++) bus_write(12'hFFF, 12'(12'h041 + k));
    @(negedge clk);
    chk("t4_full", 32'(full), 32'd1);
    chk("t4_ovf", 32'(ovf), 32'd1);
    wait_nib(10, 200);
    for (int k = 0; k < 5; k++) begin
      chk("t4_hi", 32'(nq[2*k]), 32'h14);
      chk("t4_lo", 32'(nq[2*k+1]), 32'(5'h11 + k));
    end
    settle(40);
    chk("t4_count", 32'(nq.size()), 32'd10);
    chk("t4_full_end", 32'(full), 32'd0);
    chk("t4_ovf_sticky", 32'(ovf), 32'd1);

    // Key synchronizer latency and read decode.
    rdm = 1'b1; abus = 12'hFFF;
    keys_n = 12'hFF7;
    #1 chk("t5_oe", 32'(dbus_oe), 32'd1);
    @(negedge clk);
    chk("t5_key_1clk", 32'(dbus_out), 32'hFFF);
    @(negedge clk);
    chk("t5_key_2clk", 32'(dbus_out), 32'hFF7);
    abus = 12'h123;
    #1 chk("t5_oe_other", 32'(dbus_oe), 32'd0);
    chk("t5_dout_other", 32'(dbus_out), 32'h000);
    rdm = 1'b0;

    // Reset during HI_EN with bytes still queued.
    clr_q();
    for (int k = 0; k < 4; k++) bus_write(12'hFFF, 12'h041);
    begin
      int c = 0;
      while (!lcd_e && c < 100) begin
        @(negedge clk);
        c++;
      end
      chk("t6_saw_en", 32'(lcd_e), 32'd1);
    end
    #1 rst = 1'b0;
    #1 chk("t6_e_drop", 32'(lcd_e), 32'd0);
    chk("t6_ovf_clr", 32'(ovf), 32'd0);
    chk("t6_full_clr", 32'(full), 32'd0);
    settle(2);
    rst = 1'b1;
    clr_q();
`ifdef Q2_LCD_INIT_EN
    bus_write(12'hFFF, 12'h041);
    wait_nib(14, 3000);
    for (int i = 0; i < 12; i++) chk("t6_init_seq", 32'(nq[i]), 32'(init_exp[i]));
    chk("t6_user_hi", 32'(nq[12]), 32'h14);
    chk("t6_user_lo", 32'(nq[13]), 32'h11);
    settle(20);
    chk("t6_count", 32'(nq.size()), 32'd14);
`else
    settle(40);
    chk("t6_discarded", 32'(nq.size()), 32'd0);
    bus_write(12'hFFF, 12'h041);
    wait_nib(2, 100);
    chk("t6_user_hi", 32'(nq[0]), 32'h14);
    chk("t6_user_lo", 32'(nq[1]), 32'h11);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
